// File: rtl/audio_pkg.sv
// Shared audio constants and types used by the I2S transmitter and the oscillator datapath.
package audio_pkg;

    localparam int unsigned SAMPLE_W       = 32;
    localparam int unsigned I2S_SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS     = 2 * I2S_SLOT_BITS;
    localparam int unsigned BIT_CNT_W      = $clog2(FRAME_BITS);
    localparam int unsigned SAMPLE_RATE_HZ = 48000;

    // Phase increment for 1 Hz on a 32-bit accumulator advanced once per 48 kHz frame.
    localparam logic [31:0] BASE_FREQ_STEP = 32'd89478;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } i2s_slot_e;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [BIT_CNT_W-1:0]       bit_cnt_t;
    typedef logic [FRAME_BITS-1:0]      frame_t;

    function automatic i2s_slot_e slot_of(input bit_cnt_t cnt);
        return cnt[BIT_CNT_W-1] ? SLOT_RIGHT : SLOT_LEFT;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK divider and 64-slot bit counter; all I2S timing derives from falling_evt.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 16
)
(
    input  logic     clk,
    input  logic     reset,
    output logic     falling_evt,
    output bit_cnt_t bit_cnt,
    output logic     i2s_bclk,
    output logic     i2s_lrclk
);

    localparam int unsigned    DIV_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    bit_cnt_t         bit_q, bit_d;
    i2s_slot_e        lr_q, lr_d;
    logic             wrap;

    always_comb begin
        wrap        = (div_q == DIV_LAST);
        div_d       = wrap ? '0 : div_q + 1'b1;
        bclk_d      = bclk_q ^ wrap;
        falling_evt = wrap && bclk_q;
        bit_d       = bit_q;
        lr_d        = lr_q;
        // LRCLK follows the new counter value so it changes on the same falling edge.
        if (falling_evt) begin
            bit_d = bit_q + 1'b1;
            lr_d  = slot_of(bit_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            bit_q  <= '0;
            lr_q   <= SLOT_LEFT;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            bit_q  <= bit_d;
            lr_q   <= lr_d;
        end
    end

    assign bit_cnt   = bit_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lr_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: single-entry sample buffer, frame loader and 64-bit output shifter.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sample_req,
    output logic                underrun,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    logic     falling_evt;
    bit_cnt_t bit_cnt;
    logic     load;
    logic     accept;
    sample_t  word;

    sample_t  buf_q, buf_d;
    sample_t  last_q, last_d;
    frame_t   shift_q, shift_d;
    logic     ready_q, ready_d;
    logic     sdata_q, sdata_d;
    logic     req_q, req_d;
    logic     urun_q, urun_d;

    i2s_clkgen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clkgen (
        .clk        (clk),
        .reset      (reset),
        .falling_evt(falling_evt),
        .bit_cnt    (bit_cnt),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk)
    );

    always_comb begin
        accept  = sample_valid && ready_q;
        // Load on the falling edge where bit_cnt advances 0 -> 1.
        load    = falling_evt && (bit_cnt == '0);
        word    = ready_q ? last_q : buf_q;

        buf_d   = buf_q;
        last_d  = last_q;
        shift_d = shift_q;
        ready_d = ready_q;
        sdata_d = sdata_q;
        req_d   = 1'b0;
        urun_d  = 1'b0;

        if (load) begin
            shift_d = {word, word};
            sdata_d = word[SAMPLE_W-1];
            last_d  = word;
            ready_d = 1'b1;
            req_d   = 1'b1;
            urun_d  = ready_q;
        end else if (falling_evt) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            sdata_d = shift_q[FRAME_BITS-2];
        end

        // Applied after the load so a colliding accept refills the buffer.
        if (accept) begin
            buf_d   = sample_in;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q   <= '0;
            last_q  <= '0;
            shift_q <= '0;
            ready_q <= 1'b1;
            sdata_q <= 1'b0;
            req_q   <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            sdata_q <= sdata_d;
            req_q   <= req_d;
            urun_q  <= urun_d;
        end
    end

    assign sample_ready = ready_q;
    assign sample_req   = req_q;
    assign underrun     = urun_q;
    assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with a frame/load scoreboard fed by the stimulus.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sample_req;
    logic        underrun;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;

    audio_i2s_tx #(
        .HALF_PERIOD(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_req  (sample_req),
        .underrun    (underrun),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_frames[$];
    logic        exp_ur[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] w, input logic ur);
        exp_frames.push_back(w);
        exp_ur.push_back(ur);
    endtask

    // Frame monitor: pos is the bit_cnt value at which the current BCLK rise occurs.
    int unsigned pos = 0;
    logic        armed = 1'b0;
    logic        lr_bad = 1'b0;
    logic [63:0] shreg = '0;
    logic [31:0] fw;

    always @(posedge i2s_bclk or posedge reset) begin
        if (reset) begin
            pos    = 0;
            armed  = 1'b0;
            lr_bad = 1'b0;
        end else begin
            #1;
            if (i2s_lrclk !== (pos >= 32)) lr_bad = 1'b1;
            shreg = {shreg[62:0], i2s_sdata};
            if (pos == 0) begin
                if (armed) begin
                    if (exp_frames.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_unexpected: got %h with no frame expected", shreg);
                    end else begin
                        fw = exp_frames.pop_front();
                        check("frame", shreg, {fw, fw});
                        check("lrclk_align", 64'(lr_bad), 64'd0);
                    end
                end
                armed  = 1'b1;
                lr_bad = 1'b0;
            end
            pos = (pos + 1) % 64;
        end
    end

    // Load monitor: every sample_req pops the expected underrun flag.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (sample_req) begin
                if (exp_ur.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_unexpected: got sample_req=1 expected no load");
                end else begin
                    check("underrun", 64'(underrun), 64'(exp_ur.pop_front()));
                end
            end else if (underrun) begin
                n_checks++;
                $display("FAIL underrun_stray: got 1 expected 0 outside a load");
            end
        end
    end

    task automatic wait_req(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!sample_req && cycles < 4200);
        if (!sample_req) begin
            n_checks++;
            $display("FAIL req_timeout: got no sample_req in %0d cycles expected one", cycles);
        end
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        while (!sample_ready && n < 4200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sample_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got sample_ready=0 expected 1");
        end
        sample_valid = 1'b1;
        sample_in    = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("ready_drop", 64'(sample_ready), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        int t;
        int last_t;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {58'd0, sample_ready, sample_req, underrun, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'h20);

        // Reset timing with no samples offered.
        push_exp(32'h0, 1'b1);
        reset = 1'b0;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!i2s_bclk && c < 100);
        check("first_bclk_rise", 64'(c), 64'd16);
        wait_req(c2);
        check("first_req_cycle", 64'(c + c2), 64'd32);
        push_exp(32'h0, 1'b1);
        wait_req(c);
        check("req_period", 64'(c), 64'd2048);

        // Single sample, then BCLK period.
        push_exp(32'h80000001, 1'b0);
        send(32'h80000001);
        c = 0;
        while (i2s_bclk && c < 100) begin @(posedge clk); #1; c++; end
        while (!i2s_bclk && c < 100) begin @(posedge clk); #1; c++; end
        c = 0;
        while (i2s_bclk && c < 100) begin @(posedge clk); #1; c++; end
        while (!i2s_bclk && c < 100) begin @(posedge clk); #1; c++; end
        check("bclk_period", 64'(c), 64'd32);
        wait_req(c);

        // Underrun repeat.
        push_exp(32'h12345678, 1'b0);
        send(32'h12345678);
        wait_req(c);
        push_exp(32'h12345678, 1'b1);
        wait_req(c);
        check("ready_idle_after_underrun", 64'(sample_ready), 64'd1);

        // Back-pressure: valid held high with incrementing data.
        push_exp(32'h100, 1'b0);
        push_exp(32'h101, 1'b0);
        push_exp(32'h102, 1'b0);
        sample_valid = 1'b1;
        sample_in    = 32'h100;
        t      = 0;
        last_t = 0;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (!sample_ready && n < 4200) begin @(posedge clk); #1; n++; t++; end
            @(posedge clk);
            #1;
            t++;
            if (k > 0) check("accept_interval", 64'(t - last_t), 64'd2048);
            last_t = t;
            if (k == 2) sample_valid = 1'b0;
            else        sample_in = 32'h100 + 32'(k) + 32'd1;
        end
        wait_req(c);

        // Collision: accept lands on the load edge with the buffer empty.
        push_exp(32'h102, 1'b1);
        push_exp(32'h0000ABCD, 1'b0);
        repeat (2047) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_in    = 32'h0000ABCD;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("collision_on_load", 64'(sample_req), 64'd1);
        check("collision_stored", 64'(sample_ready), 64'd0);
        wait_req(c);

        // Mid-frame reset at bit_cnt = 40.
        repeat (1250) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midframe_reset_outputs",
              {58'd0, sample_ready, sample_req, underrun, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'h20);
        check("frames_pending_at_reset", 64'(exp_frames.size()), 64'd1);
        exp_frames.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(32'h0, 1'b1);
        push_exp(32'h0, 1'b1);
        wait_req(c);
        check("req_after_reset", 64'(c), 64'd32);
        wait_req(c);
        check("req_period_after_reset", 64'(c), 64'd2048);
        repeat (2040) @(posedge clk);
        #1;
        check("frames_drained", 64'(exp_frames.size()), 64'd0);
        check("loads_drained", 64'(exp_ur.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
